// File: rtl/clock_period_meter_if.sv
// Result port of the clock period meter: one measurement per transfer over valid/ready,
// plus the timeout level and the drop pulse.
interface clock_period_meter_if #(
    parameter int pWidth = 32
) ();
    logic              iwReady;
    logic              orValid;
    logic [pWidth-1:0] orPeriod;
    logic [pWidth-1:0] orHigh;
    logic              orTimeout;
    logic              orDrop;

    modport master (
        input  iwReady,
        output orValid,
        output orPeriod,
        output orHigh,
        output orTimeout,
        output orDrop
    );

    modport slave (
        output iwReady,
        input  orValid,
        input  orPeriod,
        input  orHigh,
        input  orTimeout,
        input  orDrop
    );
endinterface

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in iwClk cycles and
// reports each completed period through a valid/ready result register.
module clock_period_meter #(
    parameter int              pWidth   = 32,
    parameter longint unsigned pTimeout = 16777216
) (
    input  logic                 iwClk,
    input  logic                 iwnRst,
    input  logic                 iwSig,
    clock_period_meter_if.master res
);
    localparam logic [pWidth-1:0] cTimeout = pWidth'(pTimeout);

    typedef enum logic {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t            state_q;
    logic              s1_q;
    logic              s2_q;
    logic              s3_q;
    logic [pWidth-1:0] count_q;
    logic [pWidth-1:0] hi_q;
    logic [pWidth-1:0] period_q;
    logic [pWidth-1:0] high_q;
    logic              valid_q;
    logic              timeout_q;
    logic              drop_q;

    logic rise;
    logic capture;
    logic accept;

    assign rise    = s2_q & ~s3_q;
    assign capture = (state_q == MEASURE) & rise;
    // The result register can take new data if it is empty or being emptied this cycle.
    assign accept  = ~valid_q | res.iwReady;

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            state_q   <= SEEK;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            count_q   <= '0;
            hi_q      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            s1_q   <= iwSig;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            drop_q <= 1'b0;

            case (state_q)
                SEEK: begin
                    if (rise) begin
                        state_q   <= MEASURE;
                        timeout_q <= 1'b0;
                        count_q   <= pWidth'(1);
                        hi_q      <= pWidth'(1);
                    end
                end
                MEASURE: begin
                    // A rise on the timeout cycle still wins: it ends a valid period.
                    if (rise) begin
                        count_q <= pWidth'(1);
                        hi_q    <= pWidth'(1);
                    end else if (count_q == cTimeout) begin
                        state_q   <= SEEK;
                        timeout_q <= 1'b1;
                        count_q   <= '0;
                        hi_q      <= '0;
                    end else begin
                        count_q <= count_q + pWidth'(1);
                        hi_q    <= hi_q + pWidth'(s2_q);
                    end
                end
                default: state_q <= SEEK;
            endcase

            if (capture) begin
                if (accept) begin
                    period_q <= count_q;
                    high_q   <= hi_q;
                    valid_q  <= 1'b1;
                end else begin
                    drop_q <= 1'b1;
                end
            end else if (valid_q && res.iwReady) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign res.orValid   = valid_q;
    assign res.orPeriod  = period_q;
    assign res.orHigh    = high_q;
    assign res.orTimeout = timeout_q;
    assign res.orDrop    = drop_q;
endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: waveform periods push expected results into a
// scoreboard, and every transfer on the result port pops and compares one entry.
module tb_clock_period_meter;
    localparam int W  = 32;
    localparam int TO = 64;

    logic iwClk  = 1'b0;
    logic iwnRst = 1'b1;
    logic iwSig  = 1'b0;

    clock_period_meter_if #(.pWidth(W)) bus ();

    clock_period_meter #(
        .pWidth  (W),
        .pTimeout(TO)
    ) dut (
        .iwClk (iwClk),
        .iwnRst(iwnRst),
        .iwSig (iwSig),
        .res   (bus)
    );

    always #5 iwClk = ~iwClk;

    int checks = 0;
    int errors = 0;

    int unsigned sb_p[$];
    int unsigned sb_h[$];

    bit armed    = 1'b0;
    bit prev_to  = 1'b0;
    int prev_len = 0;
    int prev_hi  = 0;
    int suppress = 0;

    bit bp_arm   = 1'b0;
    int bp_left  = 0;
    int bp_exp_p = 0;
    int bp_exp_h = 0;

    int drop_seen = 0;
    int to_seen   = 0;
    int results   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, bus.orValid, 0);
        chk({tag, "_period"}, bus.orPeriod, 0);
        chk({tag, "_high"}, bus.orHigh, 0);
        chk({tag, "_timeout"}, bus.orTimeout, 0);
        chk({tag, "_drop"}, bus.orDrop, 0);
    endtask

    // One clock: handle back-pressure and transfers for the coming edge, then sample after it.
    task automatic tick();
        if (bp_arm && bus.orValid) begin
            bus.iwReady = 1'b0;
            bp_left     = 25;
            bp_arm      = 1'b0;
        end else if (bp_left > 0) begin
            chk("held_valid", bus.orValid, 1);
            chk("held_period", bus.orPeriod, 64'(bp_exp_p));
            chk("held_high", bus.orHigh, 64'(bp_exp_h));
            bp_left--;
            if (bp_left == 0) bus.iwReady = 1'b1;
        end
        if (bus.orValid && bus.iwReady) begin
            if (sb_p.size() == 0) begin
                chk("unexpected_valid", bus.orValid, 0);
            end else begin
                int unsigned ep;
                int unsigned eh;
                ep = sb_p.pop_front();
                eh = sb_h.pop_front();
                results++;
                $display("result %0d: period %0d (exp %0d) high %0d (exp %0d)",
                         results, bus.orPeriod, ep, bus.orHigh, eh);
                chk("period", bus.orPeriod, 64'(ep));
                chk("high", bus.orHigh, 64'(eh));
            end
        end
        @(posedge iwClk);
        #1;
        if (bus.orDrop) drop_seen++;
        if (bus.orTimeout) to_seen++;
    endtask

    // Bookkeeping at a rising edge: it closes the previous period unless that one timed out.
    task automatic begin_period(input int h, input int l);
        if (armed && !prev_to) begin
            if (suppress > 0) begin
                suppress--;
            end else begin
                sb_p.push_back(prev_len);
                sb_h.push_back(prev_hi);
            end
        end
        armed    = 1'b1;
        prev_to  = (h + l > TO);
        prev_len = h + l;
        prev_hi  = h;
    endtask

    task automatic period(input int h, input int l);
        bit was_to;
        was_to = armed && prev_to;
        begin_period(h, l);
        for (int i = 1; i <= h + l; i++) begin
            iwSig = (i <= h);
            tick();
            if (was_to && i == 2) chk("timeout_still_set", bus.orTimeout, 1);
            if (was_to && i == 3) chk("timeout_cleared", bus.orTimeout, 0);
            if (h + l >= TO + 3 && i == TO + 2) chk("timeout_early", bus.orTimeout, 0);
            if (h + l >= TO + 3 && i == TO + 3) chk("timeout_at_limit", bus.orTimeout, 1);
        end
    endtask

    initial begin
        bus.iwReady = 1'b1;
        #2 iwnRst = 1'b0;
        #1 check_zero("reset");
        repeat (3) @(posedge iwClk);
        #1 iwnRst = 1'b1;
        repeat (3) tick();

        // Steady 5/5 wave: first rise only arms.
        drop_seen = 0;
        to_seen   = 0;
        repeat (6) period(5, 5);
        chk("steady_drop", drop_seen, 0);
        chk("steady_timeout", to_seen, 0);

        // Asymmetric duty.
        repeat (5) period(3, 7);

        // Back-pressure: a 12/6 result is held while two 10/4 results are dropped.
        period(6, 6);
        bp_arm    = 1'b1;
        bp_exp_p  = 12;
        bp_exp_h  = 6;
        drop_seen = 0;
        period(4, 6);
        suppress = 2;
        repeat (4) period(4, 6);
        chk("bp_drops", drop_seen, 2);

        // Timeout after a long low phase, then re-arm and measure again.
        period(5, 5);
        period(5, 100);
        period(5, 5);
        period(5, 5);

        // Boundary: period 64 is measured, period 65 times out.
        to_seen = 0;
        period(32, 32);
        period(32, 32);
        period(32, 33);
        chk("bound64_no_timeout", to_seen, 0);
        repeat (3) period(5, 5);

        // Reset mid-period while a result is held.
        bus.iwReady = 1'b0;
        begin_period(5, 5);
        for (int i = 1; i <= 4; i++) begin
            iwSig = 1'b1;
            tick();
        end
        chk("pre_reset_valid", bus.orValid, 1);
        #2 iwnRst = 1'b0;
        iwSig = 1'b0;
        #1 check_zero("mid_reset");
        @(posedge iwClk);
        #1 iwnRst = 1'b1;
        bus.iwReady = 1'b1;
        sb_p.delete();
        sb_h.delete();
        armed   = 1'b0;
        prev_to = 1'b0;
        repeat (3) tick();
        repeat (3) period(5, 5);
        repeat (8) tick();
        chk("scoreboard_drained", sb_p.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
